// File: rtl/ddr_traffic_gen_if.sv
// Command/read-data channel between the traffic generator and the DDR
// controller command port.
interface ddr_traffic_gen_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  // Generator side
  modport master (
    output cmd_valid, cmd_we, cmd_addr, wr_data,
    input  cmd_ready, rd_valid, rd_data
  );

  // Controller side
  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, wr_data,
    output cmd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ddr_traffic_gen.sv
// Write/read-back memory self-test: one start pulse writes NUM_WORDS patterned
// words from base_addr, reads each back (one read outstanding) and reports
// pass/fail, saturating error count and first failing address.
// Optional read timeout is enabled by defining TGEN_TIMEOUT_EN.
module ddr_traffic_gen #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                RESET_SM,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  ddr_traffic_gen_if.master   cmd,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                timeout_flag
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);

  // Reject parameter sets the index/timer logic cannot represent
  if (NUM_WORDS < 1 || NUM_WORDS > (2 ** ADDR_W) || TIMEOUT < 1) begin : g_param_check
    $error("ddr_traffic_gen: unsupported parameter values");
  end

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] seed_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;

  // Pattern word for index i under the latched mode/seed
  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m,
                                            input logic [DATA_W-1:0] s,
                                            input logic [IDX_W-1:0] i);
    case (m)
      2'b00:   pat = s;
      2'b01:   pat = s + DATA_W'(i);
      2'b10:   pat = DATA_W'(1) << (32'(i) % DATA_W);
      default: pat = i[0] ? ~s : s;
    endcase
  endfunction

  logic [IDX_W-1:0]  idx_nxt_c;
  logic              last_c;
  logic [DATA_W-1:0] exp_c;
  logic [DATA_W-1:0] wr_nxt_c;
  logic [ADDR_W-1:0] addr_nxt_c;
  logic              start_go_c;
  logic              tmo_hit_c;
  logic              word_done_c;
  logic              word_err_c;

  // Next-index payload and read-back compare terms
  assign idx_nxt_c   = idx + IDX_W'(1);
  assign last_c      = (idx == IDX_W'(NUM_WORDS - 1));
  assign exp_c       = pat(mode_q, seed_q, idx);
  assign wr_nxt_c    = pat(mode_q, seed_q, idx_nxt_c);
  assign addr_nxt_c  = base_q + ADDR_W'(idx_nxt_c);
  assign start_go_c  = start && (state == IDLE || state == DONE);
  assign word_done_c = (state == WAIT_RD) && (cmd.rd_valid || tmo_hit_c);
  assign word_err_c  = (cmd.rd_valid && (cmd.rd_data != exp_c)) || tmo_hit_c;

`ifdef TGEN_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Expiry on the TIMEOUT-th waiting cycle; a strobe in that cycle wins
  assign tmo_hit_c = (state == WAIT_RD) && !cmd.rd_valid &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Cycles spent in WAIT_RD without read data
  always_ff @(posedge clk or posedge RESET_SM) begin
    if (RESET_SM)
      tmo_cnt <= '0;
    else if (state != WAIT_RD || cmd.rd_valid || tmo_hit_c)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Sticky timeout indication, cleared by a new run
  always_ff @(posedge clk or posedge RESET_SM) begin
    if (RESET_SM)
      timeout_flag <= 1'b0;
    else if (start_go_c)
      timeout_flag <= 1'b0;
    else if (tmo_hit_c)
      timeout_flag <= 1'b1;
  end
`else
  assign tmo_hit_c    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Run sequencer with registered command and status outputs
  always_ff @(posedge clk or posedge RESET_SM) begin
    if (RESET_SM) begin
      state          <= IDLE;
      idx            <= '0;
      seed_q         <= '0;
      mode_q         <= '0;
      base_q         <= '0;
      cmd.cmd_valid  <= 1'b0;
      cmd.cmd_we     <= 1'b0;
      cmd.cmd_addr   <= '0;
      cmd.wr_data    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WRITE;
            idx            <= '0;
            seed_q         <= seed;
            mode_q         <= mode;
            base_q         <= base_addr;
            cmd.cmd_valid  <= 1'b1;
            cmd.cmd_we     <= 1'b1;
            cmd.cmd_addr   <= base_addr;
            cmd.wr_data    <= pat(mode, seed, IDX_W'(0));
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        WRITE: begin
          if (cmd.cmd_ready) begin
            if (last_c) begin
              idx          <= '0;
              state        <= READ;
              cmd.cmd_we   <= 1'b0;
              cmd.cmd_addr <= base_q;
            end else begin
              idx          <= idx_nxt_c;
              cmd.cmd_addr <= addr_nxt_c;
              cmd.wr_data  <= wr_nxt_c;
            end
          end
        end
        READ: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            state         <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (word_done_c) begin
            if (word_err_c) begin
              if (err_count != '1)
                err_count <= err_count + ERR_W'(1);
              if (err_count == '0)
                first_err_addr <= cmd.cmd_addr;
            end
            if (last_c) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !word_err_c && (err_count == '0);
            end else begin
              idx           <= idx_nxt_c;
              cmd.cmd_addr  <= addr_nxt_c;
              cmd.cmd_valid <= 1'b1;
              state         <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_traffic_gen.sv
// Self-checking bench for ddr_traffic_gen: table of directed runs, hand-written
// corner sequences (timeout / slow read, reset mid-read) and randomized runs
// against a memory model and pattern reference.
module tb_ddr_traffic_gen;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 10;
  localparam int unsigned NW  = 16;
  localparam int unsigned EW  = 8;
  localparam int unsigned TMO = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] seed;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic          busy, done, pass, timeout_flag;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  ddr_traffic_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ddr_traffic_gen #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(NW), .ERR_W(EW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .RESET_SM(rst), .start(start), .seed(seed), .mode(mode),
    .base_addr(base_addr), .cmd(bus), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  string cur_tag = "";

  logic [DW-1:0] mem [1024];
  bit            corrupt [1024];
  int            ew_addr [NW];
  logic [DW-1:0] ew_data [NW];
  int wi, ri, pcnt, drop_idx, drop_lat, stall_pct;
  bit pend, noise;
  logic [AW-1:0] paddr;

  typedef struct {
    logic [7:0] s;
    logic [1:0] m;
    logic [9:0] b;
    int ca;
    int cb;
    int e_err;
    int e_first;
    bit e_pass;
    int e_cyc;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_tag, name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_pat(input logic [1:0] m, input logic [7:0] s, input int i);
    case (m)
      2'd0:    return s;
      2'd1:    return 8'((int'(s) + i) % 256);
      2'd2:    return 8'(1 << (i % 8));
      default: return (i % 2 == 0) ? s : ~s;
    endcase
  endfunction

  // Expected error count / first failing address from corruption map and dropped reads
  task automatic ref_expect(input logic [9:0] b, input int d_idx, input int d_lat,
                            output int e_err, output int e_first);
    int a;
    bit bad;
    e_err = 0;
    e_first = 0;
    for (int i = 0; i < int'(NW); i++) begin
      a = (int'(b) + i) % 1024;
      bad = corrupt[a] || (i == d_idx && d_lat == 0);
      if (bad) begin
        if (e_err == 0) e_first = a;
        e_err = (e_err < 255) ? e_err + 1 : 255;
      end
    end
  endtask

  task automatic setup_model(input logic [7:0] s, input logic [1:0] m, input logic [9:0] b,
                             input int stl, input int d_idx, input int d_lat, input bit nz);
    for (int i = 0; i < int'(NW); i++) begin
      ew_addr[i] = (int'(b) + i) % 1024;
      ew_data[i] = ref_pat(m, s, i);
    end
    wi = 0; ri = 0; pend = 1'b0; pcnt = 0;
    drop_idx = d_idx; drop_lat = d_lat; stall_pct = stl; noise = nz;
  endtask

  // One clock: memory model, scoreboard and stall checks, inputs for next cycle
  task automatic step();
    logic acc, stl, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    acc = bus.cmd_valid && bus.cmd_ready;
    stl = bus.cmd_valid && !bus.cmd_ready;
    we  = bus.cmd_we;
    a   = bus.cmd_addr;
    d   = bus.wr_data;
    @(posedge clk);
    #1;
    if (stl)
      chk("stall_hold", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.wr_data}, {1'b1, we, a, d});
    if (acc && we) begin
      if (wi < int'(NW)) begin
        chk("wr_addr", 32'(a), ew_addr[wi]);
        chk("wr_data", 32'(d), 32'(ew_data[wi]));
      end else
        chk("write_count", wi + 1, NW);
      mem[a] = d;
      wi++;
    end
    if (acc && !we) begin
      if (ri < int'(NW)) chk("rd_addr", 32'(a), ew_addr[ri]);
      else               chk("read_count", ri + 1, NW);
      pend  = 1'b1;
      pcnt  = (ri == drop_idx) ? drop_lat : 1;
      paddr = a;
      ri++;
    end
    bus.rd_valid = 1'b0;
    bus.rd_data  = 8'($urandom);
    if (pend && pcnt != 0) begin
      if (pcnt == 20) chk("wait_busy", {busy, done}, 2'b10);
      if (pcnt == 1) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = mem[paddr] ^ {7'b0, corrupt[paddr]};
        pend = 1'b0;
      end else
        pcnt--;
    end else if (!pend && noise && $urandom_range(3) == 0)
      bus.rd_valid = 1'b1;
    bus.cmd_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
  endtask

  task automatic run(input logic [7:0] s, input logic [1:0] m, input logic [9:0] b,
                     input int stl, input int d_idx, input int d_lat, input int mid,
                     input bit nz, input int exp_cyc);
    int cyc;
    setup_model(s, m, b, stl, d_idx, d_lat, nz);
    seed = s; mode = m; base_addr = b; start = 1'b1;
    bus.rd_valid = 1'b0;
    bus.cmd_ready = 1'b1;
    step();
    start = 1'b0;
    chk("busy_valid_after_start", {busy, bus.cmd_valid}, 2'b11);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      if (nz) begin
        seed = 8'($urandom); mode = 2'($urandom); base_addr = 10'($urandom);
      end
      start = (cyc == mid);
      step();
      start = 1'b0;
      cyc++;
    end
    chk("run_completes", done, 1'b1);
    if (exp_cyc != 0) chk("cycles", cyc, exp_cyc);
    chk("writes", wi, NW);
    chk("reads", ri, NW);
  endtask

  task automatic final_chk(input int e_err, input int e_first, input bit e_pass, input bit e_tf);
    chk("done", done, 1'b1);
    chk("busy", busy, 1'b0);
    chk("cmd_valid_idle", bus.cmd_valid, 1'b0);
    chk("pass", pass, e_pass);
    chk("err_count", 32'(err_count), e_err);
    chk("first_err_addr", 32'(first_err_addr), e_first);
    chk("timeout_flag", timeout_flag, e_tf);
  endtask

  task automatic chk_reset();
    chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
    chk("rst_cmd_we", bus.cmd_we, 1'b0);
    chk("rst_cmd_addr", 32'(bus.cmd_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_first_err_addr", 32'(first_err_addr), 0);
    chk("rst_timeout_flag", timeout_flag, 1'b0);
  endtask

  initial begin
    int e_err, e_first, k, ca;
    logic [7:0] rs;
    logic [1:0] rm;
    logic [9:0] rb;

    vecs[0] = '{8'hAA, 2'b00, 10'h000, -1, -1, 0, 0, 1'b1, 48};
    vecs[1] = '{8'hFE, 2'b01, 10'h3FE, -1, -1, 0, 0, 1'b1, 48};
    vecs[2] = '{8'h0F, 2'b11, 10'h000, 5, 9, 2, 5, 1'b0, 48};
    vecs[3] = '{8'h00, 2'b10, 10'h100, -1, -1, 0, 0, 1'b1, 48};
    vecs[4] = '{8'h5A, 2'b11, 10'h3F8, 10'h001, 10'h3FF, 2, 10'h3FF, 1'b0, 48};
    vecs[5] = '{8'h33, 2'b10, 10'h3FF, 10'h00E, -1, 1, 10'h00E, 1'b0, 48};

    rst = 1'b1; start = 1'b0; seed = '0; mode = '0; base_addr = '0;
    bus.cmd_ready = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = '0;
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; corrupt[i] = 1'b0; end
    setup_model(8'h00, 2'b00, 10'h000, 0, -1, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    cur_tag = "reset";
    chk_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);

    // Directed table
    for (int v = 0; v < 6; v++) begin
      cur_tag = $sformatf("vec%0d", v);
      if (vecs[v].ca >= 0) corrupt[vecs[v].ca] = 1'b1;
      if (vecs[v].cb >= 0) corrupt[vecs[v].cb] = 1'b1;
      run(vecs[v].s, vecs[v].m, vecs[v].b, 0, -1, 1, -1, 1'b0, vecs[v].e_cyc);
      final_chk(vecs[v].e_err, vecs[v].e_first, vecs[v].e_pass, 1'b0);
      for (int i = 0; i < 1024; i++) corrupt[i] = 1'b0;
    end

`ifdef TGEN_TIMEOUT_EN
    cur_tag = "timeout_drop";
    run(8'h3C, 2'b01, 10'h000, 0, 3, 0, -1, 1'b0, 55);
    final_chk(1, 3, 1'b0, 1'b1);
    cur_tag = "timeout_edge";
    run(8'h3C, 2'b01, 10'h000, 0, 3, 8, -1, 1'b0, 55);
    final_chk(0, 0, 1'b1, 1'b0);
`else
    cur_tag = "slow_read";
    run(8'h3C, 2'b01, 10'h000, 0, 3, 40, -1, 1'b0, 87);
    final_chk(0, 0, 1'b1, 1'b0);
`endif

    // Reset asserted in the READ phase
    cur_tag = "reset_mid_read";
    setup_model(8'hAA, 2'b00, 10'h000, 0, -1, 1, 1'b0);
    seed = 8'hAA; mode = 2'b00; base_addr = '0; start = 1'b1; bus.cmd_ready = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!(bus.cmd_valid === 1'b1 && bus.cmd_we === 1'b0) && k < 200) begin
      step();
      k++;
    end
    chk("reached_read", {bus.cmd_valid, bus.cmd_we}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cur_tag = "after_reset";
    run(8'hAA, 2'b00, 10'h000, 0, -1, 1, -1, 1'b0, 48);
    final_chk(0, 0, 1'b1, 1'b0);

    // Randomized runs: stalls, spurious strobes, mid-run start, input churn
    for (int r = 0; r < 6; r++) begin
      cur_tag = $sformatf("rand%0d", r);
      rs = 8'($urandom);
      rm = 2'($urandom);
      rb = 10'($urandom);
      if ($urandom_range(1) == 1) begin
        ca = (int'(rb) + int'($urandom_range(15))) % 1024;
        corrupt[ca] = 1'b1;
      end
      ref_expect(rb, -1, 1, e_err, e_first);
      run(rs, rm, rb, 50, -1, 1, 10, 1'b1, 0);
      final_chk(e_err, e_first, (e_err == 0), 1'b0);
      for (int i = 0; i < 1024; i++) corrupt[i] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr_traffic_gen.md
# ddr_traffic_gen

Parametrised, synthesisable write/read-back traffic generator that sits between the board front end (debounced buttons, switches, LEDs) and the DDR memory controller's command port inside OuterSource. One start pulse writes `NUM_WORDS` patterned words from a base address, reads them all back and compares each one. It reports pass/fail, error count and first failing address, which replaces single-word button poking with a configurable on-board memory self-test.

## Interface
Parameters:
- `DATA_W`, 8, data word width (matches `switch`/`led`)
- `ADDR_W`, 10, word address width
- `NUM_WORDS`, 16, words per run (1 .. 2^ADDR_W)
- `ERR_W`, 8, error counter width
- `TIMEOUT`, 255, max cycles waiting for read data (only with `TGEN_TIMEOUT_EN`)

Ports:
- `clk`  in  1  controller clock, all logic on rising edge
- `RESET_SM`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle run request
- `seed`  in  DATA_W  pattern seed
- `mode`  in  2  pattern select
- `base_addr`  in  ADDR_W  first word address
- `cmd_valid`  out  1  command request
- `cmd_ready`  in  1  controller accepts command
- `cmd_we`  out  1  1 = write, 0 = read
- `cmd_addr`  out  ADDR_W  command address
- `wr_data`  out  DATA_W  write payload
- `rd_valid`  in  1  read data strobe
- `rd_data`  in  DATA_W  read data
- `busy`  out  1  run in progress
- `done`  out  1  run finished, held until next start
- `pass`  out  1  `done` and zero errors
- `err_count`  out  ERR_W  mismatches, saturating
- `first_err_addr`  out  ADDR_W  address of first mismatch
- `timeout_flag`  out  1  sticky, a read timed out

## Operation
- FSM states: IDLE, WRITE, READ, WAIT_RD, DONE.
- IDLE/DONE + `start`: latch `seed`, `mode`, `base_addr`; clear index, `err_count`, `first_err_addr`, `timeout_flag`, `done`; go to WRITE.
- `start` while `busy` is ignored.
- WRITE: `cmd_valid=1`, `cmd_we=1`, `wr_data=pat(i)`. On `cmd_valid&&cmd_ready`: i++. After the last word, i=0 and go to READ.
- READ: `cmd_valid=1`, `cmd_we=0`. On accept, go to WAIT_RD. Only one read is outstanding.
- WAIT_RD: on `rd_valid`, compare `rd_data` against `pat(i)`. A mismatch increments `err_count` (saturates at all-ones) and captures `first_err_addr` on the first error only. Then i++ and go to READ, or to DONE after the last word.
- DONE: `done=1`, `busy=0`. Stays until `start` or reset.
- `cmd_addr = (base_addr + i) mod 2^ADDR_W`. It wraps silently.
- Patterns, index i:
  - mode 00: `seed`
  - mode 01: `seed + i` mod 2^DATA_W
  - mode 10: walking one, `1 << (i mod DATA_W)`, seed ignored
  - mode 11: `seed` for even i, `~seed` for odd i
- `rd_valid` outside WAIT_RD is ignored.

## Timing
- Reset values: `cmd_valid=0`, `cmd_we=0`, `cmd_addr=0`, `wr_data=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `first_err_addr=0`, `timeout_flag=0`. State = IDLE.
- `start` sampled at edge T. `busy` and `cmd_valid` are high from T+1.
- Outputs are registered. Command payload is stable while `cmd_valid && !cmd_ready`.
- With `cmd_ready` held high and 1-cycle read latency, a run lasts NUM_WORDS + 2·NUM_WORDS cycles, and `done` rises the cycle after the last `rd_valid`.
- Reset mid-run: `cmd_valid` drops asynchronously and the run is abandoned, with no partial status.

## Configuration
- `TGEN_TIMEOUT_EN` defined:
  - A counter runs in WAIT_RD.
  - After `TIMEOUT` cycles without `rd_valid`, the word counts as one error, `timeout_flag` is set, and the FSM advances as if data arrived.
  - `rd_valid` in the expiry cycle wins, with a normal compare and no timeout.
- Undefined: no counter, WAIT_RD waits indefinitely, and `timeout_flag` is tied to 0.

## Test plan
- Defaults, mode 00, seed 0xAA, base 0, ideal memory model: 16 writes of 0xAA to addresses 0..15, then 16 reads. Expect `done=1`, `pass=1`, `err_count=0`, 48 cycles start-to-done.
- Mode 01, seed 0xFE, base 0x3FE: write data 0xFE,0xFF,0x00,... and addresses 0x3FE,0x3FF,0x000,... (wrap). Expect `pass=1`.
- Model corrupts the word at address 5 and 9 (bit 0 flip), mode 11, seed 0x0F. Expect `err_count=2`, `first_err_addr=5`, `pass=0`.
- Random `cmd_ready` stalls (50%) plus a `start` pulse mid-run. Expect the payload held stable during stalls, the mid-run start ignored, and `pass=1`.
- `TGEN_TIMEOUT_EN`, `TIMEOUT=8`, model drops the read of word 3. Expect `timeout_flag=1`, `err_count=1`, `first_err_addr=3`, run completes.
- Assert `RESET_SM` during the READ phase. Expect all outputs at reset values the same cycle. A following start completes normally.
